riscv_lsu: RTL and testbench
============================

# riscv_lsu

Load/store unit that executes the memory access requested by the main control decoder (`mem_read`, `mem_write`, with `funct3` selecting the size) against a valid/grant data-memory bus. It forms byte strobes and lane-shifted store data, then sign- or zero-extends load data. It stalls the core with a handshake FSM until the access completes and flags illegal, misaligned or timed-out accesses. It sits between the execute stage (ALU address, rs2 data) and the data memory port, and feeds the `mem2reg` = 001 write-back path.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles in REQ+WAIT before abort; 0 disables the timeout.
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous reset, active low
- `mem_read`  in  1  load request from the decoder
- `mem_write`  in  1  store request from the decoder
- `funct3`  in  3  access size/sign (instruction[14:12])
- `addr`  in  32  effective address (ALU result)
- `wdata`  in  32  store data (rs2)
- `stall`  out  1  holds the pipeline while an access is pending
- `rdata`  out  32  extended load result
- `rdata_valid`  out  1  one-cycle pulse when a load completes
- `lsu_err`  out  1  one-cycle pulse on an illegal, misaligned or timed-out access
- `dmem_req`  out  1  bus request, held until granted
- `dmem_we`  out  1  1 = write
- `dmem_addr`  out  32  word-aligned address ({addr[31:2],2'b00})
- `dmem_wdata`  out  32  lane-positioned store data
- `dmem_wstrb`  out  4  byte enables (0 for reads)
- `dmem_gnt`  in  1  request accepted
- `dmem_rvalid`  in  1  read data valid
- `dmem_rdata`  in  32  read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE:** `mem_read|mem_write` high starts an access. On that edge, latch `funct3`, `addr` and `wdata`, then go to REQ.
  - If both are high, the access is a read and `mem_write` is ignored.
  - Illegal or misaligned accesses skip the bus and go to DONE with `lsu_err`.
- **REQ:** `dmem_req`=1 and stays high until `dmem_gnt`.
  - Write plus gnt goes to DONE.
  - Read plus gnt without rvalid goes to WAIT.
  - Read plus gnt with rvalid in the same cycle captures the data and goes to DONE.
- **WAIT:** `dmem_rvalid` captures and formats the data, then goes to DONE. `dmem_req`=0.
- **DONE:** `stall`=0 for exactly one cycle, `rdata_valid`=1 for loads, `lsu_err` as latched. Always returns to IDLE.
- `stall` = (IDLE & (mem_read|mem_write)) | REQ | WAIT. It is combinational and forced 0 while `rst_n`=0.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other `funct3` is illegal.
- Store data formatting:
  - SB: wstrb = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 4'b0011<<{addr[1],1'b0}, wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 4'b1111.
- Load extraction:
  - Select the byte lane by addr[1:0], or the halfword by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Timeout counter:
  - Cleared on entry to REQ, increments every cycle in REQ/WAIT.
  - Reaching `TIMEOUT_CYCLES` (nonzero) forces DONE with `lsu_err`=1 and `rdata`=0.
  - A late `dmem_rvalid` arriving in IDLE/DONE is ignored.
- `rdata` holds its last value until the next load completes.

## Timing
- Reset (rst_n low at an edge): state IDLE, counter 0, and all of `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_wstrb`, `rdata`, `rdata_valid`, `lsu_err` go to 0.
- Reset mid-access abandons the transaction. `dmem_req` is low from the next edge.
- Bus outputs are registered. `dmem_req` rises the cycle after the start cycle T.
- Minimum latency, with gnt in the first REQ cycle and same-cycle rvalid: DONE at T+2, so `stall` is high during T and T+1.
- Each extra gnt/rvalid wait cycle adds one stall cycle.
- A new access may start in the cycle immediately after DONE.
- `dmem_addr`, `dmem_we`, `dmem_wdata` and `dmem_wstrb` are stable while `dmem_req`=1.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]≠0 raise `lsu_err`.
  - No bus request is issued and `dmem_wstrb` stays 0.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Misalignment detection is removed.
  - The address is aligned down to the access size (addr[0] cleared for halfwords, addr[1:0] for words) and the access proceeds normally.

## Test plan
- **LB:** addr=0x1003, dmem_rdata=0x80FF_FF7F, gnt+rvalid in first REQ cycle -> dmem_addr=0x1000, rdata=0xFFFF_FF80, rdata_valid pulse, 2 stall cycles.
- **SH:** addr=0x2002, wdata=0x1234_ABCD, gnt after 3 cycles -> dmem_wstrb=4'b1100, dmem_wdata=0xABCD_ABCD, 5 stall cycles, no rdata_valid.
- **LHU:** addr=0x10, rdata=0xBEEF_8001, rvalid 4 cycles after gnt -> rdata=0x0000_8001.
- **Misaligned LW** at 0x1001:
  - With the macro: lsu_err pulse, dmem_req never asserted.
  - Without the macro: word read at 0x1000.
- **Timeout:** TIMEOUT_CYCLES=8, gnt never asserted -> DONE after 8 REQ cycles, lsu_err=1, rdata=0, then IDLE.
- **Reset mid-access:** rst_n low during WAIT -> next edge dmem_req=0, state IDLE. A later rvalid produces no rdata_valid.

Source files
------------

// File: rtl/riscv_lsu.sv
// Load/store unit: formats stores, extends loads, drives a valid/grant data bus and stalls the core.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_rdata_valid,
  output logic        o_lsu_err,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_wstrb,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic [1:0]  o_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 1;

  logic [1:0]  r_state;
  logic [31:0] r_cnt;
  logic        r_is_read;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_rdata;
  logic        r_rdata_valid;
  logic        r_lsu_err;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;
  logic [3:0]  r_dmem_wstrb;

  logic        w_start;
  logic        w_illegal;
  logic        w_misalign;
  logic [1:0]  w_lo;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic        w_timeout;

  assign w_start = i_mem_read | i_mem_write;

  // A read wins when both requests are raised, so legality follows the read table then.
  always_comb begin
    if (i_mem_read) w_illegal = (i_funct3[1:0] == 2'b11) || (i_funct3 == 3'b110);
    else            w_illegal = i_funct3[2] || (i_funct3[1:0] == 2'b11);
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_lo       = i_addr[1:0];
  assign w_misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
  always_comb begin
    case (i_funct3[1:0])
      2'b01:   w_lo = {i_addr[1], 1'b0};
      2'b10:   w_lo = 2'b00;
      default: w_lo = i_addr[1:0];
    endcase
  end
`endif

  always_comb begin
    case (i_funct3[1:0])
      2'b00: begin
        w_strb  = 4'b0001 << w_lo;
        w_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        w_strb  = 4'b0011 << {w_lo[1], 1'b0};
        w_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        w_strb  = 4'b1111;
        w_wdata = i_wdata;
      end
    endcase
  end

  always_comb begin
    case (r_addr_lo)
      2'd0:    w_byte = i_dmem_rdata[7:0];
      2'd1:    w_byte = i_dmem_rdata[15:8];
      2'd2:    w_byte = i_dmem_rdata[23:16];
      default: w_byte = i_dmem_rdata[31:24];
    endcase
    w_half = r_addr_lo[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = i_dmem_rdata;
    endcase
  end

  assign w_timeout = TO_EN && (r_cnt == TO_LAST);

  // Bus handshake: o_dmem_req and its address/data/strobes are held steady until a cycle
  // with i_dmem_gnt high; read data is taken on the first i_dmem_rvalid at or after that grant.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 32'd0;
      r_is_read     <= 1'b0;
      r_funct3      <= 3'd0;
      r_addr_lo     <= 2'd0;
      r_rdata       <= 32'd0;
      r_rdata_valid <= 1'b0;
      r_lsu_err     <= 1'b0;
      r_dmem_req    <= 1'b0;
      r_dmem_we     <= 1'b0;
      r_dmem_addr   <= 32'd0;
      r_dmem_wdata  <= 32'd0;
      r_dmem_wstrb  <= 4'd0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_lsu_err     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_is_read <= i_mem_read;
            r_funct3  <= i_funct3;
            r_addr_lo <= w_lo;
            if (w_illegal || w_misalign) begin
              r_lsu_err <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_dmem_req   <= 1'b1;
              r_dmem_we    <= ~i_mem_read;
              r_dmem_addr  <= {i_addr[31:2], 2'b00};
              r_dmem_wdata <= w_wdata;
              r_dmem_wstrb <= i_mem_read ? 4'd0 : w_strb;
              r_cnt        <= 32'd0;
              r_state      <= S_REQ;
            end
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 32'd1;
          if (i_dmem_gnt) begin
            r_dmem_req   <= 1'b0;
            r_dmem_wstrb <= 4'd0;
            if (!r_is_read) begin
              r_state <= S_DONE;
            end else if (i_dmem_rvalid) begin
              r_rdata       <= w_load;
              r_rdata_valid <= 1'b1;
              r_state       <= S_DONE;
            end else begin
              r_state <= S_WAIT;
            end
          end else if (w_timeout) begin
            r_dmem_req   <= 1'b0;
            r_dmem_wstrb <= 4'd0;
            r_lsu_err    <= 1'b1;
            r_rdata      <= 32'd0;
            r_state      <= S_DONE;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 32'd1;
          if (i_dmem_rvalid) begin
            r_rdata       <= w_load;
            r_rdata_valid <= 1'b1;
            r_state       <= S_DONE;
          end else if (w_timeout) begin
            r_lsu_err <= 1'b1;
            r_rdata   <= 32'd0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_stall = i_rst_n & (((r_state == S_IDLE) & w_start) |
                              (r_state == S_REQ) | (r_state == S_WAIT));
  assign o_rdata       = r_rdata;
  assign o_rdata_valid = r_rdata_valid;
  assign o_lsu_err     = r_lsu_err;
  assign o_dmem_req    = r_dmem_req;
  assign o_dmem_we     = r_dmem_we;
  assign o_dmem_addr   = r_dmem_addr;
  assign o_dmem_wdata  = r_dmem_wdata;
  assign o_dmem_wstrb  = r_dmem_wstrb;
  assign o_state       = r_state;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed cases from the access rules plus randomized accesses
// checked against an arithmetic reference model.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, rdata_valid, lsu_err;
  logic [31:0] rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [1:0]  state;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_rdata = 32'd0;

  riscv_lsu #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
    .o_stall(stall), .o_rdata(rdata), .o_rdata_valid(rdata_valid), .o_lsu_err(lsu_err),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_wdata(dmem_wdata), .o_dmem_wstrb(dmem_wstrb),
    .i_dmem_gnt(dmem_gnt), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
    .o_state(state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic bit m_legal(input bit rd, input logic [2:0] f3);
    if (rd) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    int unsigned v;
    int size;
    size = 1 << f3[1:0];
    if (size == 1) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!f3[2] && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2) begin
      v = (w >> (8 * off)) & 32'hFFFF;
      if (!f3[2] && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // driver: one access from request to the first non-stalled cycle (DONE)
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int gd, input int rvd, input logic [31:0] rw);
    bit legal, bad, tmo, done, exp_valid;
    int size, off, total, exp_stall, exp_reqs, n_stall, reqs, g;
    logic [3:0]  e_strb;
    logic [31:0] e_wd, exp_rd;
    legal = m_legal(rd, f3);
    size  = 1 << f3[1:0];
    off   = int'(a[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    bad = !legal || ((off % size) != 0);
`else
    bad = !legal;
    off = off - (off % size);
`endif
    total = gd + 1 + (rd ? rvd : 0);
    tmo   = !bad && (total > 8);
    e_strb = 4'd0;
    e_wd   = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (!rd && i >= off && i < off + size) e_strb[i] = 1'b1;
      e_wd[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    exp_rd = m_rdata;
    if (!bad && !tmo && rd) exp_rd = m_load(f3, off, rw);
    if (tmo) exp_rd = 32'd0;
    m_rdata = exp_rd;
    exp_q.push_back(exp_rd);
    exp_valid = rd && !bad && !tmo;
    exp_stall = 1 + (bad ? 0 : (tmo ? 8 : total));
    exp_reqs  = bad ? 0 : ((gd + 1 > 8) ? 8 : gd + 1);

    @(negedge clk);
    check("idle_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = rw;
    #1;
    n_stall = stall ? 1 : 0;
    reqs = 0; g = -1; done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      #1;
      if (!stall) begin
        done = 1'b1;
        if (!(tmo && rd)) check("done_rdata_valid", {31'd0, rdata_valid}, {31'd0, exp_valid});
        check("done_lsu_err", {31'd0, lsu_err}, {31'd0, bad || tmo});
        check("done_rdata", rdata, exp_q.pop_front());
        if (bad) check("bad_wstrb", {28'd0, dmem_wstrb}, 32'd0);
      end else begin
        n_stall++;
        if (dmem_req) begin
          reqs++;
          check("req_addr", dmem_addr, {a[31:2], 2'b00});
          check("req_we", {31'd0, dmem_we}, {31'd0, !rd});
          check("req_wstrb", {28'd0, dmem_wstrb}, {28'd0, e_strb});
          if (!rd) check("req_wdata", dmem_wdata, e_wd);
          if (reqs == gd + 1) begin
            dmem_gnt = 1'b1;
            g = c;
          end
        end
        if (rd && g >= 0 && c == g + rvd) dmem_rvalid = 1'b1;
      end
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("stall_cycles", n_stall, exp_stall);
    check("req_cycles", reqs, exp_reqs);
  endtask

  initial begin
    // clock/reset block
    rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2; addr = 32'h0;
    wdata = 32'h0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_bus", dmem_addr | dmem_wdata | {28'd0, dmem_wstrb} | {31'd0, dmem_we}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_pulses", {30'd0, rdata_valid, lsu_err}, 32'd0);
    mem_read = 1'b0;
    rst_n = 1'b1;

    // directed cases
    do_access(1, 0, 3'b000, 32'h1003, 32'h0, 0, 0, 32'h80FF_FF7F);        // LB
    check("lb_value", rdata, 32'hFFFF_FF80);
    do_access(0, 1, 3'b001, 32'h2002, 32'h1234_ABCD, 3, 0, 32'h0);        // SH
    do_access(1, 0, 3'b101, 32'h10, 32'h0, 0, 4, 32'hBEEF_8001);          // LHU
    check("lhu_value", rdata, 32'h0000_8001);
    do_access(1, 0, 3'b010, 32'h1001, 32'h0, 0, 1, 32'hCAFE_F00D);        // misaligned LW
    do_access(0, 1, 3'b010, 32'h3003, 32'h5555_AAAA, 1, 0, 32'h0);        // misaligned SW
    do_access(1, 0, 3'b011, 32'h40, 32'h0, 0, 0, 32'h1);                  // illegal load
    do_access(0, 1, 3'b100, 32'h40, 32'h1, 0, 0, 32'h1);                  // illegal store
    do_access(1, 1, 3'b100, 32'h22, 32'h0, 2, 2, 32'h0081_7F00);          // both high -> LBU
    do_access(1, 0, 3'b010, 32'h44, 32'h0, 99, 0, 32'h1234_5678);         // timeout
    do_access(0, 1, 3'b000, 32'h45, 32'h0000_00A5, 0, 0, 32'h0);          // right after DONE

    // reset during WAIT, then a stray rvalid
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h80; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_read = 1'b0; dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_req", {31'd0, dmem_req}, 32'd0);
    check("midrst_state", {30'd0, state}, 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    rst_n = 1'b1; m_rdata = 32'd0;
    @(negedge clk);
    dmem_rvalid = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("late_rvalid_valid", {31'd0, rdata_valid}, 32'd0);
    check("late_rvalid_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    check("late_rvalid_valid2", {31'd0, rdata_valid}, 32'd0);

    // randomized accesses
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      do_access(kind != 1, kind != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
